// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the OpenRAM port arbiter.
// Holds bus widths, the timeout counter width and the arbiter state encoding.
package wb_pkg;

  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter2.sv
// Two-way round-robin grant with lock for a shared Wishbone slave.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   req_i[1:0]     : per-master request (cyc & stb)
//   cyc_i[1:0]     : per-master cycle, holds the grant while high
//   grant_o[1:0]   : one-hot owner decoded from the state register, 00 when idle
module wb_rr_arbiter2
  import wb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] cyc_i,
  output logic [1:0] grant_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  // State and last-served register; last starts at 1 so m0 wins the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state: grant only from IDLE, release when the owner drops cyc
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i[0] && req_i[1]) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (req_i[0]) begin
          state_d = ST_OWN0;
        end else if (req_i[1]) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!cyc_i[0]) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!cyc_i[1]) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // One-hot grant decode
  always_comb begin
    grant_o = 2'b00;
    case (state_q)
      ST_OWN0: grant_o = 2'b01;
      ST_OWN1: grant_o = 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the OpenRAM wrapper port.
// Round-robin grant held for a whole cycle, combinational slave mux and
// return path, and a stall timeout that error-terminates the owner.
// Ports:
//   wb_clk_i, wb_rst_i      : clock, asynchronous active-high reset
//   m0_*/m1_* inputs        : master cyc/stb/we/sel/adr/dat
//   m0_*/m1_* outputs       : ack/err/read data back to each master
//   s_* outputs / s_*_i     : request to and response from the OpenRAM wrapper
//   grant_o                 : one-hot current owner, 00 when idle
module wb_ram_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic [1:0]       grant_o
);

  logic [1:0]        req;
  logic [1:0]        cyc;
  logic              own_cyc;
  logic              own_stb;
  logic              timeout_hit;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              abort_q, abort_d;
  logic [1:0]        err_q, err_d;

  assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign cyc = {m1_cyc_i, m0_cyc_i};

  wb_rr_arbiter2 u_arb (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .req_i   (req),
    .cyc_i   (cyc),
    .grant_o (grant_o)
  );

  // Slave mux and return path; abort masks both the strobe and any late ack
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (grant_o[0]) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i & ~abort_q;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      own_cyc  = m0_cyc_i;
      own_stb  = m0_stb_i;
      m0_ack_o = s_ack_i & ~abort_q;
      m0_dat_o = s_dat_i;
    end else if (grant_o[1]) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i & ~abort_q;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      own_cyc  = m1_cyc_i;
      own_stb  = m1_stb_i;
      m1_ack_o = s_ack_i & ~abort_q;
      m1_dat_o = s_dat_i;
    end
  end

  // Strobe still unanswered after TIMEOUT counted wait cycles
  assign timeout_hit = s_stb_o & ~s_ack_i & (wait_cnt_q == WAIT_W'(TIMEOUT));

  // Wait counter, abort flag and one-cycle error pulse for the owner
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    abort_d    = abort_q;
    err_d      = 2'b00;
    if (!s_stb_o || s_ack_i || !own_cyc || timeout_hit) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
    if (timeout_hit) begin
      abort_d = 1'b1;
      err_d   = grant_o;
    end else if (!own_stb) begin
      // Owner released its strobe (or nobody owns the bus): abort is over
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_cnt_q <= '0;
      abort_q    <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
    end
  end

  assign m0_err_o = err_q[0];
  assign m1_err_o = err_q[1];

endmodule

// File: tb/tb_wb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_wb_ram_arbiter;

  localparam int unsigned TO     = 8;
  localparam int unsigned BUDGET = 60;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
  logic [3:0]  m_sel  [2];
  logic [31:0] m_adr  [2];
  logic [31:0] m_dat  [2];
  logic [31:0] m_rdat [2];
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic        s_ack = 1'b0;
  logic [31:0] s_rdat = '0;
  logic [1:0]  grant;

  logic [31:0] mem [256];
  logic        slave_en;
  logic        force_ack;

  exp_t q0[$];
  exp_t q1[$];
  int   order_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_cyc_i (m_cyc[0]),
    .m0_stb_i (m_stb[0]),
    .m0_we_i  (m_we[0]),
    .m0_sel_i (m_sel[0]),
    .m0_adr_i (m_adr[0]),
    .m0_dat_i (m_dat[0]),
    .m0_ack_o (m_ack[0]),
    .m0_err_o (m_err[0]),
    .m0_dat_o (m_rdat[0]),
    .m1_cyc_i (m_cyc[1]),
    .m1_stb_i (m_stb[1]),
    .m1_we_i  (m_we[1]),
    .m1_sel_i (m_sel[1]),
    .m1_adr_i (m_adr[1]),
    .m1_dat_i (m_dat[1]),
    .m1_ack_o (m_ack[1]),
    .m1_err_o (m_err[1]),
    .m1_dat_o (m_rdat[1]),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_rdat),
    .grant_o  (grant)
  );

  // RAM slave: one wait state, byte-lane writes, optional forced stray ack
  always @(posedge clk) begin
    if (rst) begin
      s_ack <= 1'b0;
    end else if (s_cyc && s_stb && !s_ack && slave_en) begin
      s_ack  <= 1'b1;
      s_rdat <= mem[s_adr[9:2]];
      if (s_we) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        end
      end
    end else begin
      s_ack <= force_ack;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_exp(input int m, input exp_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Monitor: every ack/err presented to a master pops that master's queue
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (m_ack[m] || m_err[m]) begin
          exp_t e;
          logic have;
          have = 1'b0;
          e    = '0;
          if (m == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (m == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp m%0d: got ack=%b err=%b expected none", m, m_ack[m], m_err[m]);
          end else begin
            check($sformatf("resp_is_err_m%0d", m), 32'(m_err[m]), 32'(e.err));
            if (m_ack[m]) check($sformatf("ack_owner_m%0d", m), 32'(grant[m]), 32'd1);
            if (e.chk && m_ack[m]) check($sformatf("rdata_m%0d", m), m_rdat[m], e.dat);
          end
          order_q.push_back(m);
        end
      end
    end
  end

  // One Wishbone cycle of 'beats' consecutive words; expected data increments per beat
  task automatic wb_cycle(input int m, input logic we, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [3:0] sel,
                          input logic [31:0] exp_rdat, input int beats, input logic exp_err);
    int   n;
    exp_t e;
    m_cyc[m] = 1'b1;
    m_we[m]  = we;
    m_sel[m] = sel;
    for (int b = 0; b < beats; b++) begin
      e.err = exp_err;
      e.chk = !we;
      e.dat = exp_rdat + 32'(b);
      push_exp(m, e);
      m_stb[m] = 1'b1;
      m_adr[m] = adr + 32'(4 * b);
      m_dat[m] = wdat + 32'(b);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(m_ack[m] || m_err[m]) && n < int'(BUDGET));
      if (!(m_ack[m] || m_err[m])) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_resp_m%0d: got no ack/err within %0d cycles expected a response", m, BUDGET);
      end
      @(posedge clk); #1;
    end
    m_stb[m] = 1'b0;
    m_cyc[m] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    int n;
    int stb_cnt;
    exp_t e;
    int exp_order [5];

    rst       = 1'b1;
    m_cyc     = '0;
    m_stb     = '0;
    m_we      = '0;
    slave_en  = 1'b1;
    force_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = '0;
      m_adr[i] = '0;
      m_dat[i] = '0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | 32'(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_s_stb", 32'(s_stb), 32'd0);
    check("rst_s_adr", s_adr, 32'd0);
    check("rst_s_dat", s_wdat, 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_m0_dat", m_rdat[0], 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single m0 write: grant one cycle after the request, slave sees write fields
    fork
      wb_cycle(0, 1'b1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 32'h0, 1, 1'b0);
      begin
        @(negedge clk);
        check("w1_grant_idle", 32'(grant), 32'd0);
        check("w1_stb_idle", 32'(s_stb), 32'd0);
        @(negedge clk);
        check("w1_grant", 32'(grant), 32'h1);
        check("w1_s_stb", 32'(s_stb), 32'd1);
        check("w1_s_we", 32'(s_we), 32'd1);
        check("w1_s_adr", s_adr, 32'h3000_0010);
        check("w1_s_dat", s_wdat, 32'hA5A5_1234);
        check("w1_s_sel", 32'(s_sel), 32'hF);
        @(negedge clk);
        check("w1_m0_ack", 32'(m_ack[0]), 32'd1);
        check("w1_m1_ack", 32'(m_ack[1]), 32'd0);
        check("w1_m1_dat", m_rdat[1], 32'd0);
      end
    join

    // Partial byte write then read-backs by the other master
    wb_cycle(0, 1'b1, 32'h3000_0014, 32'hFFFF_BEEF, 4'h3, 32'h0, 1, 1'b0);
    wb_cycle(1, 1'b0, 32'h3000_0014, 32'h0, 4'hF, 32'hD000_BEEF, 1, 1'b0);
    wb_cycle(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hA5A5_1234, 1, 1'b0);

    // Simultaneous requests: strict alternation m0, m1, m0, m1
    order_q.delete();
    fork
      begin
        wb_cycle(0, 1'b1, 32'h3000_0020, 32'h0000_0A00, 4'hF, 32'h0, 1, 1'b0);
        wb_cycle(0, 1'b1, 32'h3000_0024, 32'h0000_0A01, 4'hF, 32'h0, 1, 1'b0);
      end
      begin
        wb_cycle(1, 1'b1, 32'h3000_0028, 32'h0000_0A02, 4'hF, 32'h0, 1, 1'b0);
        wb_cycle(1, 1'b1, 32'h3000_002C, 32'h0000_0A03, 4'hF, 32'h0, 1, 1'b0);
      end
    join
    exp_order = '{0, 1, 0, 1, 0};
    check("tie_count", 32'(order_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      check($sformatf("tie_order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

    // m1 4-beat burst holds the grant while m0 waits
    order_q.delete();
    fork
      wb_cycle(1, 1'b0, 32'h3000_0080, 32'h0, 4'hF, 32'hD000_0020, 4, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        wb_cycle(0, 1'b0, 32'h3000_0040, 32'h0, 4'hF, 32'hD000_0010, 1, 1'b0);
      end
    join
    exp_order = '{1, 1, 1, 1, 0};
    check("burst_count", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < order_q.size(); i++)
      check($sformatf("burst_order_%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

    // Read back the interleaved writes as one m0 burst
    wb_cycle(0, 1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'h0000_0A00, 4, 1'b0);

    // Timeout: slave silent, err after TO+1 strobe cycles, stray ack swallowed
    slave_en = 1'b0;
    e = '{err: 1'b1, chk: 1'b0, dat: 32'h0};
    push_exp(0, e);
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_we[0]  = 1'b0;
    m_sel[0] = 4'hF;
    m_adr[0] = 32'h3000_0100;
    n = 0;
    stb_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (s_stb) stb_cnt++;
    end while (!m_err[0] && n < int'(BUDGET));
    check("to_err_seen", 32'(m_err[0]), 32'd1);
    check("to_stb_cycles", 32'(stb_cnt), 32'(TO + 1));
    check("to_stb_dropped", 32'(s_stb), 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("to_err_width_%0d", i), 32'(m_err[0]), 32'd0);
      check($sformatf("to_late_ack_%0d", i), 32'(m_ack[0]), 32'd0);
      check($sformatf("to_stb_held_%0d", i), 32'(s_stb), 32'd0);
    end
    @(posedge clk); #1;
    m_stb[0]  = 1'b0;
    force_ack = 1'b0;
    slave_en  = 1'b1;
    @(posedge clk); #1;
    // Same cycle, fresh strobe after abort release is served normally
    e = '{err: 1'b0, chk: 1'b1, dat: 32'hD000_0040};
    push_exp(0, e);
    m_stb[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_ack[0] && n < int'(BUDGET));
    check("to_retry_ack", 32'(m_ack[0]), 32'd1);
    @(posedge clk); #1;
    m_stb[0] = 1'b0;
    m_cyc[0] = 1'b0;
    @(posedge clk); #1;

    // Reset during a stalled m0 read
    slave_en = 1'b0;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_adr[0] = 32'h3000_0000;
    repeat (3) @(negedge clk);
    check("rst_mid_pre_grant", 32'(grant), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_mid_s_stb", 32'(s_stb), 32'd0);
    check("rst_mid_s_adr", s_adr, 32'd0);
    check("rst_mid_ack_err", 32'({m_ack, m_err}), 32'd0);
    check("rst_mid_m0_dat", m_rdat[0], 32'd0);
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    @(posedge clk); #1;
    rst      = 1'b0;
    slave_en = 1'b1;
    @(posedge clk); #1;

    // Post-reset m1-only request is granted normally
    fork
      wb_cycle(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 32'hA5A5_1234, 1, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        check("post_rst_grant_m1", 32'(grant), 32'h2);
      end
    join

    repeat (3) @(posedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
